// File: rtl/corelet_ctrl_pkg.sv
// corelet_ctrl_pkg
//   Shared definitions for the corelet tile sequencer: FSM state encoding and
//   the bit positions of the 7-bit corelet instruction bus.
package corelet_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_FILL  = 3'd1,
    S_W_LOAD  = 3'd2,
    S_W_DRAIN = 3'd3,
    S_A_FILL  = 3'd4,
    S_EXEC    = 3'd5,
    S_OUT_RD  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam int INST_KERNEL_LOAD = 0;
  localparam int INST_EXECUTE     = 1;
  localparam int INST_L0_WR       = 2;
  localparam int INST_L0_RD       = 3;
  localparam int INST_IFIFO_RD    = 4;
  localparam int INST_IFIFO_WR    = 5;
  localparam int INST_OFIFO_RD    = 6;

  localparam logic [6:0] INST_IDLE = 7'd0;

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// ctrl_cnt
//   Loadable down-counter with zero flag. Load has priority over decrement;
//   decrement saturates at zero.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   load         load count with load_val this cycle
//   load_val     value to load
//   dec          decrement by one (ignored when already zero)
//   count        current value
//   zero         count == 0
module ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl
//   Tile sequencer for one corelet: streams col weight words then len activation
//   words from xmem into L0, issues kernel-load and execute, then drains OFIFO
//   psum rows into pmem.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start                 1-cycle pulse, honoured only in IDLE
//   len                   activation vectors per tile (saturated to L0_DEPTH)
//   w_base/a_base/p_base  xmem weight/activation and pmem psum base addresses
//   o_ready               L0 not-full; a low level withholds new xmem reads
//   o_valid               OFIFO holds a full psum row
//   inst                  corelet instruction bus (bit map in corelet_ctrl_pkg)
//   xmem_cen/xmem_addr    xmem read strobe (active low) and address
//   pmem_wen/pmem_addr    pmem write strobe (active low) and address
//   busy, done            not-IDLE level, 1-cycle completion pulse
//   state_dbg             current FSM state
//   perf_cycles/perf_stalls  only when CORELET_CTRL_PERF_EN is defined
// Handshake: an xmem read issued with xmem_cen=0 in cycle t returns data that is
//   written into L0 (inst l0_wr) in cycle t+1; an ofifo_rd in cycle t is written
//   to pmem (pmem_wen=0) in cycle t+1.
module corelet_ctrl
  import corelet_ctrl_pkg::*;
#(
  parameter int bw       = 4,
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int psum_bw  = 16,
  parameter int addr_w   = 11,
  parameter int L0_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] len,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] a_base,
  input  logic [addr_w-1:0] p_base,
  input  logic              o_ready,
  input  logic              o_valid,
  output logic [6:0]        inst,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_addr,
  output logic              busy,
  output logic              done,
`ifdef CORELET_CTRL_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stalls,
`endif
  output state_t            state_dbg
);

  localparam int CW = $clog2(L0_DEPTH + 1);
  localparam logic [addr_w-1:0] ONE_A    = addr_w'(1);
  localparam logic [addr_w-1:0] DEPTH_A  = addr_w'(L0_DEPTH);
  localparam logic [addr_w-1:0] COL_A    = addr_w'(col);
  localparam logic [addr_w-1:0] COL_M1   = addr_w'(col - 1);
  localparam logic [addr_w-1:0] DRAIN_M1 = addr_w'(row + col - 1);
  localparam logic [CW:0]       DEPTH_C  = (CW + 1)'(L0_DEPTH);

  if (bw < 1 || psum_bw < bw || row < 1 || col < 1 || L0_DEPTH >= (1 << addr_w)) begin : g_param_check
    $error("corelet_ctrl: unsupported parameter combination");
  end

  state_t            state, state_nx;
  logic [addr_w-1:0] len_q, a_base_q, p_base_q;
  logic [addr_w-1:0] rd_addr, wr_idx;
  logic [addr_w-1:0] len_sat;
  logic              inflight;   // xmem read issued last cycle; lands in L0 now
  logic              wr_pend;    // ofifo_rd issued last cycle; pmem write now
  logic [CW-1:0]     credit;     // L0 occupancy as seen by the sequencer
  logic [CW:0]       occ;
  logic              room;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [addr_w-1:0] cnt_val, cnt;

  logic rd_issue, l0_rd, kload, exec, ofifo_rd, done_c;

  ctrl_cnt #(.W(addr_w)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign len_sat = (len > DEPTH_A) ? DEPTH_A : len;
  // Outstanding read counts against L0 capacity before it is written.
  assign occ  = {1'b0, credit} + (CW + 1)'(inflight);
  assign room = (occ < DEPTH_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Fill phases count remaining reads; timed phases load N-1 and leave at zero.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    rd_issue = 1'b0;
    l0_rd    = 1'b0;
    kload    = 1'b0;
    exec     = 1'b0;
    ofifo_rd = 1'b0;
    done_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = COL_A;
          state_nx = (len == '0) ? S_DONE : S_W_FILL;
        end
      end
      S_W_FILL, S_A_FILL: begin
        if (!cnt_zero) begin
          if (room && o_ready) begin
            rd_issue = 1'b1;
            cnt_dec  = 1'b1;
          end
        end else if (!inflight) begin
          cnt_load = 1'b1;
          if (state == S_W_FILL) begin
            cnt_val  = COL_M1;
            state_nx = S_W_LOAD;
          end else begin
            cnt_val  = len_q - ONE_A;
            state_nx = S_EXEC;
          end
        end
      end
      S_W_LOAD: begin
        l0_rd   = 1'b1;
        kload   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = DRAIN_M1;
          state_nx = S_W_DRAIN;
        end
      end
      S_W_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = len_q;
          state_nx = S_A_FILL;
        end
      end
      S_EXEC: begin
        l0_rd   = 1'b1;
        exec    = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = len_q;
          state_nx = S_OUT_RD;
        end
      end
      S_OUT_RD: begin
        if (o_valid && !cnt_zero) begin
          ofifo_rd = 1'b1;
          cnt_dec  = 1'b1;
        end
        if (wr_pend && (wr_idx == len_q - ONE_A)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done_c   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q    <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      rd_addr  <= '0;
      wr_idx   <= '0;
      inflight <= 1'b0;
      wr_pend  <= 1'b0;
      credit   <= '0;
    end else begin
      inflight <= rd_issue;
      wr_pend  <= ofifo_rd;
      if (state == S_IDLE && start) begin
        len_q    <= len_sat;
        a_base_q <= a_base;
        p_base_q <= p_base;
        rd_addr  <= w_base;
        wr_idx   <= '0;
      end else begin
        if (state == S_W_DRAIN && cnt_zero) begin
          rd_addr <= a_base_q;
        end else if (rd_issue) begin
          rd_addr <= rd_addr + ONE_A;
        end
        if (wr_pend) begin
          wr_idx <= wr_idx + ONE_A;
        end
      end
      case ({inflight, l0_rd})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_comb begin
    inst                   = INST_IDLE;
    inst[INST_KERNEL_LOAD] = kload;
    inst[INST_EXECUTE]     = exec;
    inst[INST_L0_WR]       = inflight;
    inst[INST_L0_RD]       = l0_rd;
    inst[INST_IFIFO_RD]    = 1'b0;
    inst[INST_IFIFO_WR]    = 1'b0;
    inst[INST_OFIFO_RD]    = ofifo_rd;
  end

  assign xmem_cen  = ~rd_issue;
  assign xmem_addr = rd_issue ? rd_addr : '0;
  assign pmem_wen  = ~wr_pend;
  assign pmem_addr = wr_pend ? (p_base_q + wr_idx) : '0;
  assign busy      = (state != S_IDLE);
  assign done      = done_c;
  assign state_dbg = state;

`ifdef CORELET_CTRL_PERF_EN
  logic fill_stall;
  assign fill_stall = ((state == S_W_FILL) || (state == S_A_FILL)) && !cnt_zero && !rd_issue;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (state != S_IDLE) perf_cycles <= perf_cycles + 32'd1;
      if (fill_stall)      perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
module tb_corelet_ctrl;
  import corelet_ctrl_pkg::*;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset, start, o_ready, o_valid;
  logic [AW-1:0] len, w_base, a_base, p_base;
  logic [6:0]    inst;
  logic          xmem_cen, pmem_wen, busy, done;
  logic [AW-1:0] xmem_addr, pmem_addr;
  state_t        state_dbg;
`ifdef CORELET_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_stalls;
`endif

  corelet_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .w_base    (w_base),
    .a_base    (a_base),
    .p_base    (p_base),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .inst      (inst),
    .xmem_cen  (xmem_cen),
    .xmem_addr (xmem_addr),
    .pmem_wen  (pmem_wen),
    .pmem_addr (pmem_addr),
    .busy      (busy),
    .done      (done),
`ifdef CORELET_CTRL_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  logic [AW-1:0] exp_xq[$];
  logic [AW-1:0] exp_pq[$];
  logic [AW-1:0] exp_a;

  int cyc = 0;
  int kl_cnt, ex_cnt, of_cnt, rd_cnt, wr_cnt, done_cnt;
  int done_cyc, last_kl_cyc, a_first_cyc, last_wr_cyc, first_rd_cyc, first_cyc;
  logic prev_rd = 1'b0;
  int noise_mode = 0;

  // monitor: sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      if (!xmem_cen) begin
        n_checks++;
        if (exp_xq.size() == 0) begin
          n_fail++;
          $display("FAIL xmem_unexpected: read at addr %0d, required no read", xmem_addr);
        end else begin
          exp_a = exp_xq.pop_front();
          if (xmem_addr !== exp_a) begin
            n_fail++;
            $display("FAIL xmem_addr: got %0d, required %0d", xmem_addr, exp_a);
          end
        end
        if (rd_cnt == 0) first_rd_cyc = cyc;
        if (rd_cnt == 8) a_first_cyc = cyc;
        rd_cnt++;
        n_checks++;
        if (o_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL read_while_not_ready: o_ready %b, required 1", o_ready);
        end
      end
      n_checks++;
      if (inst[INST_L0_WR] !== prev_rd) begin
        n_fail++;
        $display("FAIL l0_wr_latency: got %b, required %b", inst[INST_L0_WR], prev_rd);
      end
      prev_rd = !xmem_cen;
      if (!pmem_wen) begin
        n_checks++;
        if (exp_pq.size() == 0) begin
          n_fail++;
          $display("FAIL pmem_unexpected: write at addr %0d, required no write", pmem_addr);
        end else begin
          exp_a = exp_pq.pop_front();
          if (pmem_addr !== exp_a) begin
            n_fail++;
            $display("FAIL pmem_addr: got %0d, required %0d", pmem_addr, exp_a);
          end
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (inst[INST_KERNEL_LOAD]) begin
        kl_cnt++;
        last_kl_cyc = cyc;
      end
      if (inst[INST_EXECUTE]) ex_cnt++;
      if (inst[INST_OFIFO_RD]) begin
        of_cnt++;
        n_checks++;
        if (o_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL ofifo_rd_without_valid: o_valid %b, required 1", o_valid);
        end
      end
      n_checks++;
      if ((inst[INST_EXECUTE] & inst[INST_KERNEL_LOAD]) !== 1'b0 || inst[5:4] !== 2'b00) begin
        n_fail++;
        $display("FAIL inst_encoding: inst %b, required exec/kload exclusive and [5:4]=0", inst);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // background input noise: 1 = random o_ready/o_valid, 2 = o_valid toggling
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (noise_mode == 1) begin
        o_ready = ($urandom_range(0, 3) != 0);
        o_valid = ($urandom_range(0, 1) == 1);
      end else if (noise_mode == 2) begin
        o_valid = ~o_valid;
      end
    end
  end

  task automatic clear_stats();
    kl_cnt = 0; ex_cnt = 0; of_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    done_cyc = -1; last_kl_cyc = -1; a_first_cyc = -1; last_wr_cyc = -1; first_rd_cyc = -1;
  endtask

  task automatic push_exp(input int ls, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb, input bit with_pmem);
    logic [AW-1:0] a;
    if (ls > 0) begin
      for (int i = 0; i < 8; i++) begin a = wb + AW'(i); exp_xq.push_back(a); end
      for (int i = 0; i < ls; i++) begin a = ab + AW'(i); exp_xq.push_back(a); end
      if (with_pmem)
        for (int i = 0; i < ls; i++) begin a = pb + AW'(i); exp_pq.push_back(a); end
    end
  endtask

  // driver: one complete tile with end-of-tile checks
  task automatic run_tile(input int l, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb);
    int ls;
    ls = (l > 64) ? 64 : l;
    clear_stats();
    push_exp(ls, wb, ab, pb, 1'b1);
    @(posedge clk); #1;
    len = AW'(l); w_base = wb; a_base = ab; p_base = pb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_cyc = cyc + 1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL tile_timeout: len %0d, no done within 3000 cycles", l);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_xq.size() != 0 || exp_pq.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: xmem left %0d, pmem left %0d, required 0/0",
               exp_xq.size(), exp_pq.size());
    end
    exp_xq.delete(); exp_pq.delete();
    n_checks++;
    if (kl_cnt != ((ls > 0) ? 8 : 0) || ex_cnt != ls || of_cnt != ls || wr_cnt != ls) begin
      n_fail++;
      $display("FAIL phase_counts: kload %0d exec %0d ofifo %0d writes %0d, required %0d %0d %0d %0d",
               kl_cnt, ex_cnt, of_cnt, wr_cnt, (ls > 0) ? 8 : 0, ls, ls, ls);
    end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: pulses %0d busy %b, required 1 and 0", done_cnt, busy);
    end
    if (ls > 0) begin
      n_checks++;
      if (done_cyc - last_wr_cyc != 1) begin
        n_fail++;
        $display("FAIL done_after_write: gap %0d, required 1", done_cyc - last_wr_cyc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; o_ready = 1'b1; o_valid = 1'b1;
    len = '0; w_base = '0; a_base = '0; p_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (inst !== 7'd0 || xmem_cen !== 1'b1 || pmem_wen !== 1'b1 || xmem_addr !== '0 ||
        pmem_addr !== '0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: inst %b cen %b wen %b xa %0d pa %0d busy %b done %b state %0d, required idle values",
               inst, xmem_cen, pmem_wen, xmem_addr, pmem_addr, busy, done, state_dbg);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_tile(4, 11'd0, 11'd64, 11'd0);
    n_checks++;
    if (first_rd_cyc != first_cyc || a_first_cyc - last_kl_cyc != 17) begin
      n_fail++;
      $display("FAIL basic_timing: first read cyc %0d (required %0d), kload-to-A gap %0d (required 17)",
               first_rd_cyc, first_cyc, a_first_cyc - last_kl_cyc);
    end
`ifdef CORELET_CTRL_PERF_EN
    n_checks++;
    if (perf_cycles !== 32'(done_cyc - first_cyc + 1)) begin
      n_fail++;
      $display("FAIL perf_cycles: got %0d, required %0d", perf_cycles, done_cyc - first_cyc + 1);
    end
`endif
  endtask

  task automatic test_len_zero();
    run_tile(0, 11'd3, 11'd9, 11'd7);
    n_checks++;
    if (done_cyc != first_cyc) begin
      n_fail++;
      $display("FAIL len_zero_done: done at cyc %0d, required %0d", done_cyc, first_cyc);
    end
  endtask

  task automatic test_ready_stall();
    fork
      run_tile(4, 11'd5, 11'd100, 11'd200);
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (state_dbg != S_A_FILL && n < 500);
        @(posedge clk); #1;
        o_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
`ifdef CORELET_CTRL_PERF_EN
    n_checks++;
    if (perf_stalls !== 16'd5) begin
      n_fail++;
      $display("FAIL perf_stalls: got %0d, required 5", perf_stalls);
    end
`endif
  endtask

  task automatic test_saturate();
    run_tile(100, 11'd1000, 11'd2000, 11'd2040);
  endtask

  task automatic test_reset_exec();
    int n;
    clear_stats();
    push_exp(8, 11'd20, 11'd40, 11'd0, 1'b0);
    @(posedge clk); #1;
    len = 11'd8; w_base = 11'd20; a_base = 11'd40; p_base = 11'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (state_dbg != S_EXEC && n < 500);
    n_checks++;
    if (state_dbg != S_EXEC) begin
      n_fail++;
      $display("FAIL reach_exec: state %0d, required %0d", state_dbg, S_EXEC);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (inst !== 7'd0 || xmem_cen !== 1'b1 || pmem_wen !== 1'b1 || xmem_addr !== '0 ||
        pmem_addr !== '0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset: inst %b cen %b wen %b busy %b done %b state %0d, required idle values",
               inst, xmem_cen, pmem_wen, busy, done, state_dbg);
    end
    n_checks++;
    if (exp_xq.size() != 0 || ex_cnt == 0) begin
      n_fail++;
      $display("FAIL mid_reset_progress: xmem left %0d exec %0d, required 0 and >0", exp_xq.size(), ex_cnt);
    end
    exp_xq.delete(); exp_pq.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    run_tile(3, 11'd8, 11'd16, 11'd32);
  endtask

  task automatic test_valid_toggle();
    o_valid = 1'b0;
    noise_mode = 2;
    run_tile(6, 11'd0, 11'd300, 11'd500);
    noise_mode = 0;
    @(posedge clk); #1;
    o_valid = 1'b1;
  endtask

  task automatic test_back_to_back();
    fork
      run_tile(5, 11'd50, 11'd60, 11'd70);
      begin
        repeat (20) @(posedge clk);
        #1;
        len = 11'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    run_tile(2, 11'd2046, 11'd2047, 11'd2045);
  endtask

  task automatic test_random();
    noise_mode = 1;
    for (int t = 0; t < 3; t++)
      run_tile($urandom_range(1, 70), AW'($urandom_range(0, 2047)), AW'($urandom_range(0, 2047)),
               AW'($urandom_range(0, 2047)));
    noise_mode = 0;
    @(posedge clk); #1;
    o_ready = 1'b1; o_valid = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_ready_stall();
    test_saturate();
    test_reset_exec();
    test_valid_toggle();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
